// File: rtl/encoder_pkg.sv
// encoder_pkg: shared decode constants and scan FSM encoding
// Q_* are {a_now, a_old, b_now, b_old} patterns that count one step.
package encoder_pkg;
    localparam logic [3:0] Q_INC0 = 4'b1000;
    localparam logic [3:0] Q_INC1 = 4'b0111;
    localparam logic [3:0] Q_DEC0 = 4'b0010;
    localparam logic [3:0] Q_DEC1 = 4'b1101;
    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/encoder_scan_ctrl_quad_step.sv
// quad_step: one combinational quadrature decode + wrap/saturate update
// Ports: a_s/b_s synchronized pins, old_a/old_b last scanned pins,
//        value current count, wrap_en wrap(1)/clamp(0),
//        next_value updated count, changed next_value differs from value.
module quad_step
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             a_s,
    input  logic             old_a,
    input  logic             b_s,
    input  logic             old_b,
    input  logic [WIDTH-1:0] value,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] next_value,
    output logic             changed
);
    logic [3:0] q;
    logic       inc;
    logic       dec;
    logic       hold;
    assign q    = {a_s, old_a, b_s, old_b};
    assign inc  = (q == Q_INC0) || (q == Q_INC1);
    assign dec  = (q == Q_DEC0) || (q == Q_DEC1);
    // clamp only when stepping past an end with wrapping disabled
    assign hold = !wrap_en && ((inc && &value) || (dec && ~|value));
    assign next_value = hold ? value : inc ? value + 1'b1 : dec ? value - 1'b1 : value;
    assign changed    = next_value != value;
endmodule

// File: rtl/encoder_scan_ctrl.sv
// encoder_scan_ctrl: time-shared quadrature decoder for NUM_CH rotary encoders
// Ports: clk, reset (sync, active-high); enc_a/enc_b raw async pins;
//        wrap_en wrap(1)/clamp(0); load_valid/load_ch/load_value/load_ready
//        host preset handshake; values packed channel counts
//        (channel i at [i*WIDTH +: WIDTH]); changed per-channel update pulse.
module encoder_scan_ctrl
    import encoder_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8,
    parameter int DIV    = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    wrap_en,
    input  logic                    load_valid,
    input  logic [1:0]              load_ch,
    input  logic [WIDTH-1:0]        load_value,
    output logic                    load_ready,
    output logic [NUM_CH*WIDTH-1:0] values,
    output logic [NUM_CH-1:0]       changed
);
    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
    localparam logic [1:0]     LAST    = 2'(NUM_CH - 1);
    localparam logic [2:0]     NCH     = 3'(NUM_CH);

    logic [NUM_CH-1:0] a_m, a_s, b_m, b_s, old_a, old_b;
    logic [CW-1:0]     cnt;
    logic              tick;
    logic              tick_pending;
    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic              leave;
    logic              accept;
    logic [WIDTH-1:0]  val [NUM_CH];
    logic [WIDTH-1:0]  step_value;
    logic              step_changed;

    assign tick       = cnt == CNT_MAX;
    assign load_ready = state == IDLE;
    assign accept     = load_valid && load_ready;
    // a tick in the current cycle starts the scan directly; a load defers it
    assign state_n = (state == IDLE) ? ((!load_valid && (tick || tick_pending)) ? SCAN : IDLE)
                                     : ((idx == LAST) ? IDLE : SCAN);
    assign idx_n   = (state == SCAN && idx != LAST) ? idx + 2'd1 : 2'd0;
    assign leave   = state == IDLE && state_n == SCAN;

    quad_step #(.WIDTH(WIDTH)) u_step (
        .a_s       (a_s[idx]),
        .old_a     (old_a[idx]),
        .b_s       (b_s[idx]),
        .old_b     (old_b[idx]),
        .value     (val[idx]),
        .wrap_en   (wrap_en),
        .next_value(step_value),
        .changed   (step_changed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_m          <= '0;
            a_s          <= '0;
            b_m          <= '0;
            b_s          <= '0;
            old_a        <= '0;
            old_b        <= '0;
            cnt          <= '0;
            tick_pending <= 1'b0;
            state        <= IDLE;
            idx          <= 2'd0;
            val          <= '{default: '0};
            changed      <= '0;
        end else begin
            a_m          <= enc_a;
            a_s          <= a_m;
            b_m          <= enc_b;
            b_s          <= b_m;
            cnt          <= tick ? '0 : cnt + 1'b1;
            tick_pending <= (tick || tick_pending) && !leave;
            state        <= state_n;
            idx          <= idx_n;
            changed      <= '0;
            if (accept && {1'b0, load_ch} < NCH) begin
                val[load_ch]     <= load_value;
                changed[load_ch] <= 1'b1;
            end
            if (state == SCAN) begin
                old_a[idx]   <= a_s[idx];
                old_b[idx]   <= b_s[idx];
                val[idx]     <= step_value;
                changed[idx] <= step_changed;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign values[g*WIDTH +: WIDTH] = val[g];
    end
endmodule

// File: tb/tb_encoder_scan_ctrl.sv
// tb_encoder_scan_ctrl: scoreboard bench for encoder_scan_ctrl
module tb_encoder_scan_ctrl;
    localparam int NUM_CH = 3;
    localparam int WIDTH  = 8;
    localparam int DIV    = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       enc_a = '0;
    logic [NUM_CH-1:0]       enc_b = '0;
    logic                    wrap_en = 1'b1;
    logic                    load_valid = 1'b0;
    logic [1:0]              load_ch = '0;
    logic [WIDTH-1:0]        load_value = '0;
    logic                    load_ready;
    logic [NUM_CH*WIDTH-1:0] values;
    logic [NUM_CH-1:0]       changed;

    encoder_scan_ctrl #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .wrap_en   (wrap_en),
        .load_valid(load_valid),
        .load_ch   (load_ch),
        .load_value(load_value),
        .load_ready(load_ready),
        .values    (values),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        int     val;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     cur[NUM_CH];
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     cnt_m = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cnt_m <= reset ? 0 : (cnt_m == DIV - 1 ? 0 : cnt_m + 1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (changed[i]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("spurious_changed%0d", i), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("changed_channel", i, e.ch);
                        check($sformatf("changed_value%0d", i), values[i*WIDTH +: WIDTH], e.val);
                        check($sformatf("changed_cycle%0d", i), cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic wait_cnt(input int c);
        do @(negedge clk); while (cnt_m != c);
    endtask

    task automatic check_values(input string tag);
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("%s_value%0d", tag, i), values[i*WIDTH +: WIDTH], cur[i]);
    endtask

    // pins change early in the tick period so they are synchronized before the next scan
    task automatic step(input logic [2:0] a, input logic [2:0] b, input int n0, input int n1, input int n2);
        int     nv[3];
        longint base;
        nv = '{n0, n1, n2};
        wait_cnt(3);
        enc_a = a;
        enc_b = b;
        base  = cyc;
        for (int i = 0; i < NUM_CH; i++) begin
            if (nv[i] != cur[i]) sb.push_back('{i, nv[i], base + DIV - 2 + i});
            cur[i] = nv[i];
        end
        wait_cnt(1);
        check("scan_load_ready", load_ready, 0);
        wait_cnt(3);
        check_values("step");
    endtask

    task automatic load(input int ch, input int v);
        check("idle_load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_ch    = 2'(ch);
        load_value = 8'(v);
        if (ch < NUM_CH) begin
            sb.push_back('{ch, v, cyc + 1});
            cur[ch] = v;
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        longint tc;
        for (int i = 0; i < NUM_CH; i++) cur[i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle with pins low
        repeat (3 * DIV) @(negedge clk);
        check_values("idle");
        wait_cnt(4);
        check("idle_ready", load_ready, 1);

        // channel 0 clockwise: only 1000 and 0111 count
        step(3'b001, 3'b000, 1, 0, 0);
        step(3'b001, 3'b001, 1, 0, 0);
        step(3'b000, 3'b001, 2, 0, 0);
        step(3'b000, 3'b000, 2, 0, 0);

        // saturate at max, then wrap at max
        wrap_en = 1'b0;
        wait_cnt(4);
        load(1, 255);
        step(3'b010, 3'b000, 2, 255, 0);
        wrap_en = 1'b1;
        wait_cnt(4);
        load(1, 255);
        step(3'b010, 3'b010, 2, 255, 0);
        step(3'b000, 3'b010, 2, 0, 0);
        step(3'b000, 3'b000, 2, 0, 0);

        // clamp at zero, then wrap below zero
        wrap_en = 1'b0;
        step(3'b000, 3'b010, 2, 0, 0);
        step(3'b000, 3'b000, 2, 0, 0);
        wrap_en = 1'b1;
        step(3'b000, 3'b010, 2, 255, 0);
        step(3'b000, 3'b000, 2, 255, 0);

        // load in the tick cycle delays but does not drop the scan
        wait_cnt(3);
        enc_b = 3'b001;
        wait_cnt(DIV - 1);
        tc = cyc;
        load(2, 8'h80);
        sb.push_back('{0, 1, tc + 3});
        cur[0] = 1;
        @(negedge clk);
        check("delayed_scan_ready", load_ready, 0);
        wait_cnt(3);
        check_values("tickload");
        step(3'b000, 3'b000, 1, 255, 128);

        // reset during SCAN idx=1 with decrements pending on ch1 and ch2
        wait_cnt(3);
        enc_b = 3'b110;
        wait_cnt(1);
        reset = 1'b1;
        enc_a = '0;
        enc_b = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) cur[i] = 0;
        check_values("reset");
        check("reset_ready", load_ready, 1);
        check("reset_sb_empty", sb.size(), 0);
        repeat (2 * DIV) @(negedge clk);
        check_values("post_reset");

        // opposite rotation on the same tick
        wait_cnt(4);
        load(2, 10);
        step(3'b001, 3'b100, 1, 0, 9);
        step(3'b000, 3'b000, 1, 0, 9);

        // out-of-range channel is accepted and ignored
        wait_cnt(4);
        load(3, 55);
        repeat (DIV) @(negedge clk);
        check_values("bad_ch");

        repeat (2 * DIV) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
